// File: rtl/y86_pkg.sv
// Shared Y86 definitions: status encodings, run-controller states and the
// core-flag priority encoder used by both the processor top and the run controller.
package y86_pkg;

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0001;

    typedef enum logic [2:0] {
        RC_IDLE   = 3'd0,
        RC_LOAD   = 3'd1,
        RC_SETTLE = 3'd2,
        RC_RUN    = 3'd3,
        RC_DONE   = 3'd4
    } run_state_t;

    // Address faults outrank a bad opcode, which outranks a clean halt.
    function automatic logic [3:0] core_stat(
        input logic bad_mem,
        input logic bad_mem2,
        input logic in_error,
        input logic flag_halt
    );
        logic [3:0] s;
        s = STAT_AOK;
        if (bad_mem || bad_mem2) begin
            s = STAT_ADR;
        end else if (in_error) begin
            s = STAT_INS;
        end else if (flag_halt) begin
            s = STAT_HLT;
        end
        return s;
    endfunction

endpackage

// File: rtl/y86_watchdog.sv
// Run-cycle counter: counts enabled cycles, saturates at LIMIT, and flags the
// cycle whose closing edge brings the count to LIMIT.
module y86_watchdog
    import y86_pkg::*;
#(
    parameter int unsigned LIMIT = 4096,
    parameter int unsigned W     = 32
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         expire
);

    localparam logic [W-1:0] LIM    = W'(LIMIT);
    localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

    assign expire = en && (count == LIM_M1);

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (en && (count != LIM)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/y86_run_ctrl.sv
// Program-load and run controller: streams a program into instruction memory,
// then gates the Y86 core and latches its terminating status.
module y86_run_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = 1024,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned MAX_CYCLES = 4096
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              core_run,
    input  logic              flag_halt,
    input  logic              in_error,
    input  logic              bad_mem,
    input  logic              bad_mem2,
    output logic [3:0]        stat,
    output logic              timeout,
    output logic              done,
    output logic [ADDR_W:0]   load_count,
    output logic [31:0]       cycle_count
);

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] LOAD_ONE  = (ADDR_W+1)'(1);

    run_state_t        state;
    run_state_t        state_nxt;
    logic              accept;
    logic              mem_full;
    logic              flag_hit;
    logic              wd_expire;
    logic              run_en;
    logic [3:0]        flag_stat;

    logic              wr_vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [7:0]        wr_data_p1;

    assign accept    = in_valid && in_ready;
    assign mem_full  = (load_count == MEM_LIMIT);
    assign flag_stat = core_stat(bad_mem, bad_mem2, in_error, flag_halt);
    assign flag_hit  = (flag_stat != STAT_AOK);
    assign run_en    = (state == RC_RUN);

    y86_watchdog #(
        .LIMIT (MAX_CYCLES),
        .W     (32)
    ) u_watchdog (
        .clock  (clock),
        .clear  (!reset_n),
        .en     (run_en),
        .count  (cycle_count),
        .expire (wd_expire)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= RC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RC_IDLE, RC_LOAD: begin
                if (accept) begin
                    if (mem_full) begin
                        state_nxt = RC_DONE;
                    end else if (in_last) begin
                        state_nxt = RC_SETTLE;
                    end else begin
                        state_nxt = RC_LOAD;
                    end
                end
            end
            RC_SETTLE: state_nxt = RC_RUN;
            RC_RUN: begin
                if (flag_hit || wd_expire) begin
                    state_nxt = RC_DONE;
                end
            end
            RC_DONE:  state_nxt = RC_DONE;
            default:  state_nxt = RC_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        core_run = 1'b0;
        done     = 1'b0;
        case (state)
            RC_IDLE, RC_LOAD: in_ready = 1'b1;
            RC_RUN:           core_run = 1'b1;
            RC_DONE:          done     = 1'b1;
            default: ;
        endcase
    end

    // Stage p1: accepted byte becomes a memory write one cycle later.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            load_count <= '0;
            stat       <= STAT_AOK;
            timeout    <= 1'b0;
        end else begin
            wr_vld_p1 <= accept && !mem_full;
            if (accept && !mem_full) begin
                wr_addr_p1 <= load_count[ADDR_W-1:0];
                wr_data_p1 <= in_byte;
                load_count <= load_count + LOAD_ONE;
            end
            if (accept && mem_full) begin
                stat <= STAT_ADR;
            end
            if (run_en) begin
                if (flag_hit) begin
                    stat <= flag_stat;
                end else if (wd_expire) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

    assign mem_we    = wr_vld_p1;
    assign mem_waddr = wr_addr_p1;
    assign mem_wdata = wr_data_p1;

endmodule
